// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one cathode bus, N common-anode digits, dead-time blanking.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int TICK_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [4*N_DIGITS-1:0]   i_value,
    input  logic [N_DIGITS-1:0]     i_dp,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [N_DIGITS-1:0]     o_an,
    output logic                    o_frame
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q,   idx_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic [4*N_DIGITS-1:0]   val_q,   val_d;
    logic [N_DIGITS-1:0]     dp_q,    dp_d;
    logic [6:0]              seg_q,   seg_d;
    logic                    dpo_q,   dpo_d;
    logic [N_DIGITS-1:0]     an_q,    an_d;
    logic                    frame_q, frame_d;

    // Active-high segment pattern a..g for one hex nibble.
    function automatic logic [6:0] font(input logic [3:0] h);
        case (h)
            4'h0: font = 7'h3F;
            4'h1: font = 7'h06;
            4'h2: font = 7'h5B;
            4'h3: font = 7'h4F;
            4'h4: font = 7'h66;
            4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;
            4'h7: font = 7'h07;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h6F;
            4'hA: font = 7'h77;
            4'hB: font = 7'h7C;
            4'hC: font = 7'h39;
            4'hD: font = 7'h5E;
            4'hE: font = 7'h79;
            default: font = 7'h71;
        endcase
    endfunction

    function automatic logic [3:0] digit_of(input logic [4*N_DIGITS-1:0] v,
                                            input logic [IDX_W-1:0] i);
        digit_of = 4'h0;
        for (int k = 0; k < N_DIGITS; k++)
            if (k == int'(i)) digit_of = v[4*k +: 4];
    endfunction

`ifdef SEG7_SCAN_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    function automatic logic is_leading_zero(input logic [4*N_DIGITS-1:0] v,
                                             input logic [IDX_W-1:0] i);
        logic all_zero;
        all_zero = 1'b1;
        for (int k = 0; k < N_DIGITS; k++)
            if (k >= int'(i) && v[4*k +: 4] != 4'h0) all_zero = 1'b0;
        is_leading_zero = (i != '0) && all_zero;
    endfunction
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        dp_d    = dp_q;
        frame_d = 1'b0;

        if (!i_en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                    val_d   = i_value;
                    dp_d    = i_dp;
                end
                BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) state_d = ON;
                end
                ON: begin
                    if (cnt_q == TICK_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            val_d   = i_value;
                            dp_d    = i_dp;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are derived from the next state so they register alongside it.
        seg_d = 7'h7F;
        dpo_d = 1'b1;
        an_d  = '1;
        if (state_d == ON) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                an_d[k] = (k != int'(idx_d));
                if (k == int'(idx_d)) dpo_d = ~dp_d[k];
            end
            seg_d = ~font(digit_of(val_d, idx_d));
`ifdef SEG7_SCAN_LZB_EN
            if (is_leading_zero(val_d, idx_d)) seg_d = 7'h7F;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the captured value
    // registers are small and reset along with everything else so outputs are defined.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            dp_q    <= '0;
            seg_q   <= 7'h7F;
            dpo_q   <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            dp_q    <= dp_d;
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_dp    = dpo_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scan controller that shares one 7-segment cathode bus between `N_DIGITS` common-anode digits. It latches a packed hexadecimal value once per frame and cycles the digit enables. A dead-time blanking interval precedes each digit to suppress ghosting. The block sits between the counter/value logic and the board pins, replacing direct single-digit segment drive; all pin outputs are active-low.

## Interface
- `N_DIGITS`, default 4: number of digits scanned; must be ≥1.
- `TICK_DIV`, default 1000: clock cycles per digit slot, blank plus on; must be > `BLANK_CYC`.
- `BLANK_CYC`, default 16: clock cycles of blanking at the start of each slot; must be ≥1.
- `i_clk`  in  1  system clock; one clock domain.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_en`  in  1  scan enable; level-sensitive.
- `i_value`  in  4*N_DIGITS  packed hex digits; `[3:0]` is digit 0, the least significant / rightmost.
- `i_dp`  in  N_DIGITS  decimal point per digit; bit k belongs to digit k.
- `o_seg`  out  7  segment cathodes, active-low; bit0=a … bit6=g.
- `o_dp`  out  1  decimal point cathode, active-low.
- `o_an`  out  N_DIGITS  digit anode enables, active-low; at most one bit low at any time.
- `o_frame`  out  1  one-cycle pulse, active-high, marking the end of a full scan.

## Operation
- FSM states are `IDLE`, `BLANK` and `ON`. Registers: `idx` (digit index, `$clog2(N_DIGITS)` bits, min 1), `cnt` (slot cycle counter, wide enough for `TICK_DIV-1`), `val_q`, `dp_q`.
- All outputs are registered. Output values below are those present while the FSM is in the named state.
- Reset (async, while `i_rst`=1):
  - State goes to `IDLE`; `idx`=0, `cnt`=0.
  - Outputs: `o_seg`=7'h7F, `o_dp`=1, `o_an`=all ones, `o_frame`=0.
  - `val_q` and `dp_q` are cleared to 0.
- `IDLE`:
  - Outputs are off (all ones), `o_frame`=0.
  - On a cycle with `i_en`=1: go to `BLANK` with `idx`=0 and `cnt`=0, and capture `val_q`←`i_value`, `dp_q`←`i_dp`.
- `BLANK`:
  - `o_an`, `o_seg` and `o_dp` are all ones.
  - `cnt` increments. When `cnt`=`BLANK_CYC-1`, go to `ON`.
- `ON`:
  - `o_an[idx]`=0, all other anode bits are 1.
  - `o_seg`=~font(`val_q[4*idx+:4]`) and `o_dp`=~`dp_q[idx]`.
  - `cnt` increments. When `cnt`=`TICK_DIV-1`, set `cnt`=0 and go to `BLANK`, applying the following:
    - If `idx`=`N_DIGITS-1`: `idx` wraps to 0, `o_frame` pulses for one cycle (concurrent with the `ON`→`BLANK` transition), and `val_q`/`dp_q` recapture the current inputs.
    - Otherwise: `idx`+1.
- Input capture:
  - Inputs are sampled only at frame start, so all digits of one frame show one coherent value.
  - Changes to `i_value` mid-frame appear on the next frame.
- Disable:
  - `i_en`=0 in any state forces `IDLE` on the next edge: outputs off, `idx`=0, `cnt`=0, no `o_frame` pulse.
  - Re-enabling starts a fresh frame at digit 0.
- Font, active-high a..g before inversion, values 0–F:
  - 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
- Boundary cases:
  - `N_DIGITS`=1: `idx` stays 0, and `o_frame` pulses every slot.
  - A simultaneous wrap and `i_en` deassert resolves to `IDLE` with no pulse.

## Timing
- From `i_en` sampled high at edge E0: `BLANK` occupies cycles E0+1 … E0+`BLANK_CYC`. Digit 0 is lit from E0+`BLANK_CYC`+1 for `TICK_DIV-BLANK_CYC` cycles.
- Slot period is `TICK_DIV` cycles; frame period is `N_DIGITS*TICK_DIV` cycles.
- Between two lit digits, all anodes are high for exactly `BLANK_CYC` cycles.
- `o_frame` is high for exactly 1 cycle per frame, aligned with the first `BLANK` cycle of the next frame.
- Reset assertion forces outputs off asynchronously, with no clock required. Operation resumes from `IDLE` on the first edge after `i_rst` falls.

## Configuration
- Macro: `SEG7_SCAN_LZB_EN`.
- Defined (leading-zero blanking enabled):
  - At frame capture, determine the highest nonzero digit of `val_q`.
  - Digits above it show `o_seg`=7'h7F, while their anode is still cycled and `o_dp` still follows `dp_q`.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Undefined: every digit shows its font pattern, including leading zeros.
- Slot timing is identical in both builds.

## Test plan
All scenarios use `N_DIGITS`=4, `TICK_DIV`=8, `BLANK_CYC`=2.

- Reset, then `i_en`=1 with `i_value`=16'h12AF and `i_dp`=4'b0000.
  - Required: digit 0 lit 6 cycles with `o_seg`=~7'h71; digit 1 ~7'h77; digit 2 ~7'h5B; digit 3 ~7'h06.
  - Required: `o_an` walks 1110→1101→1011→0111, with 2 cycles of 1111 between digits.
- Run a full frame and count `o_frame`.
  - Required: exactly one 1-cycle pulse per 32 cycles, coincident with the `o_an`=0111→1111 transition.
- Change `i_value` from 16'h1111 to 16'h2222 mid-frame while digit 1 is lit.
  - Required: the remaining digits of that frame still show ~7'h06; the next frame shows ~7'h5B.
- Deassert `i_en` while digit 2 is lit, then reassert after 5 cycles.
  - Required: outputs all ones on the next cycle, with no `o_frame` pulse.
  - Required: restart at digit 0 after 2 blank cycles.
- Assert `i_rst` asynchronously mid-slot.
  - Required: `o_an`=4'hF, `o_seg`=7'h7F and `o_dp`=1 before the next clock edge.
  - Required: `o_frame`=0.
- With `SEG7_SCAN_LZB_EN` defined, use `i_value`=16'h0050 and `i_dp`=4'b1000.
  - Required: digits 3 and 2 show 7'h7F, and digit 3 has `o_dp`=0.
  - Required: digit 1 shows ~7'h6D and digit 0 shows ~7'h3F.
  - Required: `i_value`=16'h0000 shows only digit 0 as "0".
